// File: rtl/reg_file_if.sv
// Register-file access bundle: two combinational read ports (A1/RD1, A2/RD2)
// and one clocked write port (A3/WE3/WD3).
interface reg_file_if #(
  parameter int XLEN = 32
);
  logic [4:0]      A1;
  logic [4:0]      A2;
  logic [4:0]      A3;
  logic            WE3;
  logic [XLEN-1:0] WD3;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;

  modport master (output A1, A2, A3, WE3, WD3, input RD1, RD2);
  modport slave  (input A1, A2, A3, WE3, WD3, output RD1, RD2);
endinterface

// File: rtl/reg_file.sv
// RV-style 2R/1W integer register file; x0 is hard-wired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic     CLK,
  input  logic     RST,
  reg_file_if.slave bus
);

  // x0 has no storage, so the array starts at index 1
  logic [XLEN-1:0] r_regs [1:NREG-1];

  logic            w_wr_en;
  logic [XLEN-1:0] w_rd1_stored;
  logic [XLEN-1:0] w_rd2_stored;

  assign w_wr_en = bus.WE3 && !RST && (bus.A3 != 5'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.A3] <= bus.WD3;
    end
  end

  assign w_rd1_stored = (bus.A1 == 5'd0) ? '0 : r_regs[bus.A1];
  assign w_rd2_stored = (bus.A2 == 5'd0) ? '0 : r_regs[bus.A2];

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  // w_wr_en already excludes x0 and reset, so a forwarded value is never nonzero for x0
  assign w_fwd1  = w_wr_en && (bus.A1 == bus.A3);
  assign w_fwd2  = w_wr_en && (bus.A2 == bus.A3);
  assign bus.RD1 = w_fwd1 ? bus.WD3 : w_rd1_stored;
  assign bus.RD2 = w_fwd2 ? bus.WD3 : w_rd2_stored;
`else
  assign bus.RD1 = w_rd1_stored;
  assign bus.RD2 = w_rd2_stored;
`endif

endmodule
